// File: rtl/loop_counter.sv
// loop_counter: loads a loop limit on start, then counts from 0 up to
// (limit - OFFSET) one step per enabled cycle, pulsing done at completion.
// Starts whose limit is below OFFSET are rejected with a one-cycle err pulse.
// Optional build macro: LOOP_COUNTER_AUTORELOAD_EN -- when defined, reaching
// the terminal count wraps the count back to 0 and keeps running instead of
// parking in DONE.
module loop_counter #(
  parameter int WIDTH  = 4,
  parameter int OFFSET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             initCount,
  input  logic             enCount,
  input  logic [WIDTH-1:0] NregIn,
  output logic [WIDTH-1:0] countOut,
  output logic             nEqual,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // OFFSET widened once so every limit comparison happens in WIDTH+1 bits.
  localparam logic [WIDTH:0] OFFSET_EXT = (WIDTH + 1)'(OFFSET);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   term;
  logic             at_term;
  logic             start_legal;

  // Terminal count is derived from the latched limit only, so NregIn wiggling
  // during a run cannot disturb it. An accepted start guarantees term >= 0.
  assign term        = {1'b0, limit_q} - OFFSET_EXT;
  assign at_term     = ({1'b0, count_q} == term);
  assign start_legal = ({1'b0, NregIn} >= OFFSET_EXT);

  // Next-state and next-output logic; initCount outranks every other request.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (initCount) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            count_d = '0;
            if (start_legal) begin
              limit_d = NregIn;
              state_d = S_RUN;
            end else begin
              // Rejected start keeps the previous limit and falls back to idle.
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (enCount) begin
            if (at_term) begin
              done_d = 1'b1;
`ifdef LOOP_COUNTER_AUTORELOAD_EN
              count_d = '0;
`else
              state_d = S_DONE;
`endif
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        default: begin
          // Unused encoding: recover to a clean idle.
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset taking top priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // All outputs come from registered state only.
  assign countOut = count_q;
  assign busy     = (state_q == S_RUN);
  assign nEqual   = (state_q == S_RUN) && at_term;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_loop_counter.sv
// tb_loop_counter: directed vector table plus hand sequences and random
// traffic, all checked against a behavioural model of the loop counter.
// Honours LOOP_COUNTER_AUTORELOAD_EN in the same way as the design.
module tb_loop_counter;
  localparam int WIDTH  = 4;
  localparam int OFFSET = 2;

  logic             clk = 1'b0;
  logic             rst, start, initCount, enCount;
  logic [WIDTH-1:0] NregIn;
  logic [WIDTH-1:0] countOut;
  logic             nEqual, done, busy, err;

  loop_counter #(.WIDTH(WIDTH), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst(rst), .start(start), .initCount(initCount),
    .enCount(enCount), .NregIn(NregIn), .countOut(countOut),
    .nEqual(nEqual), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: "running" flag plus an integer count and limit.
  bit m_run;
  int m_cnt;
  int m_lim;
  bit m_done;
  bit m_err;

  function automatic void model_step(bit r, bit s, bit i, bit e, int n);
    if (!r) begin
      m_run = 0; m_cnt = 0; m_lim = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (i) begin
        m_run = 0;
        m_cnt = 0;
      end else if (!m_run) begin
        if (s) begin
          m_cnt = 0;
          if (n >= OFFSET) begin
            m_lim = n;
            m_run = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (e) begin
        if (m_cnt == m_lim - OFFSET) begin
          m_done = 1;
`ifdef LOOP_COUNTER_AUTORELOAD_EN
          m_cnt = 0;
`else
          m_run = 0;
`endif
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  endfunction

  typedef struct {
    string      tag;
    bit         r, s, i, e;
    logic [3:0] n;
    int         cnt;
    bit         bsy, neq, dn, er;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string tag, bit r, bit s, bit i, bit e, int n,
                              int cnt, bit bsy, bit neq, bit dn, bit er);
    vec_t v;
    v.tag = tag; v.r = r; v.s = s; v.i = i; v.e = e; v.n = 4'(n);
    v.cnt = cnt; v.bsy = bsy; v.neq = neq; v.dn = dn; v.er = er;
    tbl.push_back(v);
  endfunction

  // Drive one cycle of inputs, advance the model, and settle past the edge.
  task automatic apply(bit r, bit s, bit i, bit e, logic [3:0] n);
    rst = r; start = s; initCount = i; enCount = e; NregIn = n;
    model_step(r, s, i, e, int'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, int cnt, bit bsy, bit neq, bit dn, bit er);
    vectors++;
    if (countOut !== WIDTH'(cnt) || busy !== bsy || nEqual !== neq ||
        done !== dn || err !== er) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d busy=%b neq=%b done=%b err=%b, want cnt=%0d busy=%b neq=%b done=%b err=%b",
               tag, countOut, busy, nEqual, done, err, cnt, bsy, neq, dn, er);
    end else begin
      $display("ok   %s: cnt=%0d busy=%b neq=%b done=%b err=%b",
               tag, countOut, busy, nEqual, done, err);
    end
  endtask

  task automatic check_model(string tag);
    check(tag, m_cnt, m_run, m_run && (m_cnt == m_lim - OFFSET), m_done, m_err);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; initCount = 1'b0; enCount = 1'b0; NregIn = '0;

    //   tag        r s i e  n   cnt bsy neq dn er
    add("rst0",     0,1,0,1, 6,  0,  0,  0,  0, 0);
    add("rst1",     0,1,0,1, 6,  0,  0,  0,  0, 0);
`ifndef LOOP_COUNTER_AUTORELOAD_EN
    add("start6",   1,1,0,0, 6,  0,  1,  0,  0, 0);
    add("cnt1",     1,0,0,1, 6,  1,  1,  0,  0, 0);
    add("cnt2",     1,0,0,1, 6,  2,  1,  0,  0, 0);
    add("cnt3",     1,0,0,1, 6,  3,  1,  0,  0, 0);
    add("cnt4",     1,0,0,1, 6,  4,  1,  1,  0, 0);
    add("done",     1,0,0,1, 6,  4,  0,  0,  1, 0);
    add("donehold", 1,0,0,1, 6,  4,  0,  0,  0, 0);
    add("rej1",     1,1,0,0, 1,  0,  0,  0,  0, 1);
    add("rejclr",   1,0,0,0, 1,  0,  0,  0,  0, 0);
    add("start15",  1,1,0,0, 15, 0,  1,  0,  0, 0);
    add("r15c1",    1,0,0,1, 3,  1,  1,  0,  0, 0);
    add("r15gap",   1,1,0,0, 3,  1,  1,  0,  0, 0);
    add("r15c2",    1,0,0,1, 3,  2,  1,  0,  0, 0);
`else
    add("ar4start", 1,1,0,0, 4,  0,  1,  0,  0, 0);
    add("ar1",      1,0,0,1, 4,  1,  1,  0,  0, 0);
    add("ar2",      1,0,0,1, 4,  2,  1,  1,  0, 0);
    add("arwrap",   1,0,0,1, 4,  0,  1,  0,  1, 0);
    add("ar1b",     1,0,0,1, 4,  1,  1,  0,  0, 0);
    add("ar2b",     1,0,0,1, 4,  2,  1,  1,  0, 0);
    add("arwrap2",  1,0,0,1, 4,  0,  1,  0,  1, 0);
`endif

    foreach (tbl[k]) begin
      apply(tbl[k].r, tbl[k].s, tbl[k].i, tbl[k].e, tbl[k].n);
      check(tbl[k].tag, tbl[k].cnt, tbl[k].bsy, tbl[k].neq, tbl[k].dn, tbl[k].er);
    end

    // Long run with enable gaps and a changing NregIn that must be ignored.
    apply(1, 1, 1, 0, 4'd0);  check_model("clr");
    apply(1, 1, 0, 0, 4'd15); check_model("long_start");
    for (int k = 0; k < 22; k++) begin
      apply(1, (k % 4) == 1, 0, (k % 3) != 2, 4'(k));
      check_model("long_run");
    end

    // initCount beats start and enCount mid-run.
    apply(1, 1, 1, 0, 4'd0);  check_model("ic_clr");
    apply(1, 1, 0, 0, 4'd15); check_model("ic_start");
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 0, 1, 4'd15);
      check_model("ic_cnt");
    end
    apply(1, 1, 1, 1, 4'd15); check_model("ic_abort");
    apply(1, 0, 0, 1, 4'd15); check_model("ic_idle");

    // term == 0: nEqual high straight away, first enabled cycle completes.
    apply(1, 1, 0, 0, 4'd2);  check_model("t0_start");
    apply(1, 0, 0, 0, 4'd2);  check_model("t0_hold");
    apply(1, 0, 0, 1, 4'd2);  check_model("t0_fin");
    apply(1, 0, 0, 1, 4'd2);  check_model("t0_after");

    // Reset beats everything mid-run; first released edge is a plain idle cycle.
    apply(1, 1, 0, 0, 4'd9);  check_model("mr_start");
    apply(1, 0, 0, 1, 4'd9);  check_model("mr_cnt");
    apply(0, 1, 1, 1, 4'd9);  check_model("mr_rst");
    apply(1, 0, 0, 1, 4'd9);  check_model("mr_idle");
    apply(1, 1, 0, 0, 4'd0);  check_model("mr_rej");

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      apply($urandom_range(49) != 0, $urandom_range(5) == 0,
            $urandom_range(19) == 0, $urandom_range(3) != 0,
            4'($urandom_range(15)));
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/loop_counter.md
LOOP_COUNTER -- requirements
Module: loop_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the counter and limit width in bits (legal range 2..16).
REQ-002 SHALL have parameter OFFSET, default 2, the value subtracted from the limit to form the terminal count (legal range 0..2^WIDTH-1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, which captures NregIn and begins a run.
REQ-006 SHALL have port initCount, input, 1, a synchronous abort/clear to idle.
REQ-007 SHALL have port enCount, input, 1, which advances the count by one per cycle while running.
REQ-008 SHALL have port NregIn, input, WIDTH, the loop limit sampled only on an accepted start.
REQ-009 SHALL have port countOut, output, WIDTH, the current count (registered).
REQ-010 SHALL have port nEqual, output, 1, the terminal-count flag (combinational from registered state).
REQ-011 SHALL have port done, output, 1, a one-cycle registered pulse at run completion.
REQ-012 SHALL have port busy, output, 1, which is high while in RUN.
REQ-013 SHALL have port err, output, 1, a one-cycle registered pulse when a start is rejected.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL compute term = limitReg - OFFSET in WIDTH+1 bits; a start is legal only if NregIn >= OFFSET.
REQ-016 IDLE or DONE, start=1, legal limit: latch NregIn into limitReg, countOut<=0, next state RUN.
REQ-017 IDLE or DONE, start=1, NregIn < OFFSET: err=1 next cycle, state IDLE, countOut<=0, limitReg unchanged.
REQ-018 RUN: start SHALL be ignored; NregIn changes SHALL be ignored.
REQ-019 RUN, enCount=1, countOut != term: countOut<=countOut+1.
REQ-020 RUN, enCount=0: countOut holds.
REQ-021 nEqual SHALL be 1 iff state==RUN and countOut==term; 0 in IDLE and DONE.
REQ-022 RUN, enCount=1, countOut==term: countOut holds at term, next state DONE, done=1 for exactly that next cycle.
REQ-023 term==0 (NregIn==OFFSET): nEqual SHALL be high in the first RUN cycle; the first enabled cycle completes the run.
REQ-024 DONE: countOut holds term, busy=0, and the FSM waits for start or initCount.
REQ-025 initCount=1 SHALL have priority over start and enCount in every state: countOut<=0, state IDLE, done/err 0 next cycle.
REQ-026 busy SHALL equal (state==RUN), registered-state-derived, with no combinational path from inputs.
REQ-027 countOut SHALL never exceed term in RUN and SHALL never wrap past 2^WIDTH-1.

Reset
REQ-028 rst=0 at a rising edge SHALL force state IDLE, countOut=0, limitReg=0, done=0, err=0; nEqual=0 and busy=0 follow.
REQ-029 Reset SHALL take priority over initCount, start and enCount, including mid-run.
REQ-030 The first edge with rst=1 SHALL behave as a normal IDLE cycle.

Configuration
REQ-031 Macro LOOP_COUNTER_AUTORELOAD_EN, when defined: RUN, enCount=1, countOut==term SHALL set countOut<=0, remain in RUN, and pulse done next cycle; DONE is then reachable only as an unused encoding, and the run continues until initCount or rst.
REQ-032 Without LOOP_COUNTER_AUTORELOAD_EN, completion SHALL follow REQ-022.

Verification (WIDTH=4, OFFSET=2)
REQ-033 rst=0 two cycles with start=1, enCount=1 -> countOut=0, busy=0, done=0, err=0, nEqual=0.
REQ-034 NregIn=6, start one cycle, enCount=1 continuously -> countOut 0,1,2,3,4; nEqual high only at 4; next cycle done=1 once, busy=0, countOut holds 4.
REQ-035 NregIn=1, start -> err=1 for one cycle, busy stays 0, countOut=0.
REQ-036 NregIn=15 start, then NregIn=3 during RUN -> run ends at countOut=13; enCount gaps hold the count.
REQ-037 RUN at countOut=3 with initCount=1, enCount=1, start=1 in the same cycle -> countOut=0, IDLE, no done pulse.
REQ-038 With LOOP_COUNTER_AUTORELOAD_EN, NregIn=4, enCount=1 -> countOut 0,1,2,0,1,2,...; done pulses once per three enabled cycles; busy stays 1.
